branch_predictor: RTL and testbench

- Parametrised branch target buffer (BTB) with per-entry saturating direction counters.
- Sits beside the IF stage and predicts taken/target for the fetch PC one cycle after lookup.
- Trained by the ID-stage branch resolution: taken/not-taken, target, and kind for conditional branches, JAL, JR/JALR.
- Successor to the purely combinational ID-stage branch decision. Adds prediction state, aliasing tags, training, and flush.

---
 rtl/branch_predictor_if.sv | 33 +++
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup/response and ID-side training bundle for the branch predictor.
// The master drives lookups, updates and flush; the slave (the predictor) returns the registered prediction.
interface branch_predictor_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  lookup_en;
  logic [ADDR_WIDTH-1:0] lookup_pc;
  logic                  pred_valid;
  logic                  pred_hit;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  update_en;
  logic [ADDR_WIDTH-1:0] update_pc;
  logic [1:0]            update_kind;
  logic                  update_taken;
  logic [ADDR_WIDTH-1:0] update_target;
  logic                  update_pred_taken;
  logic                  flush;

  modport master (
    output lookup_en, lookup_pc,
    output update_en, update_pc, update_kind, update_taken, update_target, update_pred_taken,
    output flush,
    input  pred_valid, pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  lookup_en, lookup_pc,
    input  update_en, update_pc, update_kind, update_taken, update_target, update_pred_taken,
    input  flush,
    output pred_valid, pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor.sv
// Tagged BTB with saturating direction counters; 1-cycle lookup latency, no backpressure (always accepts).
// Optional lookup/mispredict counters are enabled with `define BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int CNT_WIDTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bus
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]        stat_lookups,
  output logic [31:0]        stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

  logic [ENTRIES-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_q    [ENTRIES];

  logic                  pred_valid_q;
  logic                  pred_hit_q;
  logic                  pred_taken_q;
  logic [ADDR_WIDTH-1:0] pred_target_q;

  logic [INDEX_WIDTH-1:0] lk_idx;
  logic [TAG_WIDTH-1:0]   lk_tag;
  logic                   lk_hit;
  logic                   lk_taken;

  logic [INDEX_WIDTH-1:0] up_idx;
  logic [TAG_WIDTH-1:0]   up_tag;
  logic                   up_hit;
  logic                   wr_en;
  logic [CNT_WIDTH-1:0]   wr_cnt;
  logic [ADDR_WIDTH-1:0]  wr_target;

  logic unused_bits;
  assign unused_bits = ^{bus.lookup_pc, bus.update_pc, bus.update_pred_taken};

  assign lk_idx = bus.lookup_pc[INDEX_WIDTH+1:2];
  assign lk_tag = bus.lookup_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];
  assign up_idx = bus.update_pc[INDEX_WIDTH+1:2];
  assign up_tag = bus.update_pc[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2];

  // Reads see the table before this edge's write; a concurrent flush masks the hit.
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !bus.flush;
  assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_WIDTH-1];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_cnt    = cnt_q[up_idx];
    wr_target = target_q[up_idx];
    if (bus.update_en && !bus.flush) begin
      case (bus.update_kind)
        2'b00: begin
          if (up_hit) begin
            wr_en = 1'b1;
            if (bus.update_taken) begin
              wr_target = bus.update_target;
              if (cnt_q[up_idx] != CNT_MAX) wr_cnt = cnt_q[up_idx] + CNT_WIDTH'(1);
            end else if (cnt_q[up_idx] != '0) begin
              wr_cnt = cnt_q[up_idx] - CNT_WIDTH'(1);
            end
          end else if (bus.update_taken) begin
            wr_en     = 1'b1;
            wr_cnt    = CNT_WEAK;
            wr_target = bus.update_target;
          end
        end
        2'b01, 2'b10: begin
          wr_en     = 1'b1;
          wr_cnt    = CNT_MAX;
          wr_target = bus.update_target;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (bus.flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= wr_target;
      cnt_q[up_idx]    <= wr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= bus.lookup_en;
      pred_hit_q    <= bus.lookup_en && lk_hit;
      pred_taken_q  <= bus.lookup_en && lk_taken;
      pred_target_q <= (bus.lookup_en && lk_taken) ? target_q[lk_idx] : '0;
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_hit    = pred_hit_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_target = pred_target_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic mispredict;
  assign mispredict = bus.update_en && (bus.update_kind != 2'b11) &&
                      (bus.update_taken != bus.update_pred_taken);

  // Counters survive flush; they only clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bus.lookup_en && stat_lookups != 32'hFFFF_FFFF)
        stat_lookups <= stat_lookups + 32'd1;
      if (mispredict && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expected responses, a monitor pops and compares them.
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  int   next_id;
  bit   done;

  typedef struct {
    int          cyc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
    int          id;
  } exp_t;

  exp_t exp_q[$];

  branch_predictor_if #(.ADDR_WIDTH(32)) bus ();

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(
    .ADDR_WIDTH (32),
    .INDEX_WIDTH(6),
    .TAG_WIDTH  (8),
    .CNT_WIDTH  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    bus.lookup_en = 1'b0;
    bus.update_en = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic set_lookup(input logic [31:0] pc, input logic hit, input logic taken,
                            input logic [31:0] target);
    exp_t e;
    bus.lookup_en = 1'b1;
    bus.lookup_pc = pc;
    e.cyc    = cyc;
    e.hit    = hit;
    e.taken  = taken;
    e.target = target;
    e.id     = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic set_update(input logic [1:0] kind, input logic [31:0] pc, input logic taken,
                            input logic [31:0] target);
    bus.update_en         = 1'b1;
    bus.update_kind       = kind;
    bus.update_pc         = pc;
    bus.update_taken      = taken;
    bus.update_target     = target;
    bus.update_pred_taken = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic hit, input logic taken,
                        input logic [31:0] target);
    set_lookup(pc, hit, taken, target);
    tick();
  endtask

  task automatic update(input logic [1:0] kind, input logic [31:0] pc, input logic taken,
                        input logic [31:0] target);
    set_update(kind, pc, taken, target);
    tick();
  endtask

  // Stimulus
  initial begin
    done                  = 1'b0;
    next_id               = 0;
    rst                   = 1'b0;
    bus.lookup_en         = 1'b0;
    bus.lookup_pc         = '0;
    bus.update_en         = 1'b0;
    bus.update_pc         = '0;
    bus.update_kind       = 2'b00;
    bus.update_taken      = 1'b0;
    bus.update_target     = '0;
    bus.update_pred_taken = 1'b0;
    bus.flush             = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    lookup(32'h0040_0010, 1'b0, 1'b0, 32'h0);                    // id0 cold miss
    update(2'b00, 32'h0040_0010, 1'b1, 32'h0040_0100);           // allocate, cnt=2
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);            // id1
    update(2'b00, 32'h0040_0010, 1'b0, 32'h0);                   // cnt=1
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0);                    // id2
    update(2'b00, 32'h0040_0010, 1'b0, 32'h0);                   // cnt=0
    update(2'b00, 32'h0040_0010, 1'b0, 32'h0);                   // stays 0
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0);                    // id3
    for (int i = 0; i < 3; i++) update(2'b00, 32'h0040_0010, 1'b1, 32'h0040_0100);
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);            // id4 cnt=3
    update(2'b00, 32'h0040_0010, 1'b1, 32'h0040_0100);           // saturates at 3
    update(2'b00, 32'h0040_0010, 1'b0, 32'h0);                   // cnt=2
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);            // id5

    lookup(32'h0040_0110, 1'b0, 1'b0, 32'h0);                    // id6 alias miss
    update(2'b00, 32'h0040_0110, 1'b1, 32'h0040_0200);
    lookup(32'h0040_0010, 1'b0, 1'b0, 32'h0);                    // id7 evicted
    lookup(32'h0040_0110, 1'b1, 1'b1, 32'h0040_0200);            // id8

    update(2'b10, 32'h0040_0020, 1'b1, 32'h0040_0300);
    lookup(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300);            // id9
    update(2'b01, 32'h0040_0030, 1'b1, 32'h0040_0400);
    lookup(32'h0040_0030, 1'b1, 1'b1, 32'h0040_0400);            // id10
    update(2'b11, 32'h0040_0050, 1'b1, 32'h0040_0500);
    lookup(32'h0040_0050, 1'b0, 1'b0, 32'h0);                    // id11 reserved kind
    update(2'b00, 32'h0040_0060, 1'b0, 32'h0040_0600);
    lookup(32'h0040_0060, 1'b0, 1'b0, 32'h0);                    // id12 not-taken miss

    bus.flush = 1'b1;
    set_update(2'b01, 32'h0040_0070, 1'b1, 32'h0040_0700);
    set_lookup(32'h0040_0020, 1'b0, 1'b0, 32'h0);                // id13 masked by flush
    tick();
    lookup(32'h0040_0020, 1'b0, 1'b0, 32'h0);                    // id14
    lookup(32'h0040_0070, 1'b0, 1'b0, 32'h0);                    // id15 update dropped
    lookup(32'h0040_0110, 1'b0, 1'b0, 32'h0);                    // id16

    set_update(2'b00, 32'h0040_0040, 1'b1, 32'h0040_0500);
    set_lookup(32'h0040_0040, 1'b0, 1'b0, 32'h0);                // id17 read-before-write
    tick();
    lookup(32'h0040_0040, 1'b1, 1'b1, 32'h0040_0500);            // id18

    repeat (3) tick();
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    checks = 0;
    errors = 0;
    @(negedge clk);
    checks++;
    if ({bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_target} !== 35'h0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b hit=%b taken=%b target=%h, want all 0",
               bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_target);
    end
    wait (rst === 1'b1);
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc + 1 == cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.pred_valid !== 1'b1 || bus.pred_hit !== e.hit ||
            bus.pred_taken !== e.taken || bus.pred_target !== e.target) begin
          errors++;
          $display("FAIL lookup_id%0d: got valid=%b hit=%b taken=%b target=%h, want valid=1 hit=%b taken=%b target=%h",
                   e.id, bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_target,
                   e.hit, e.taken, e.target);
        end
      end else begin
        checks++;
        if ({bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_target} !== 35'h0) begin
          errors++;
          $display("FAIL idle_cycle%0d: got valid=%b hit=%b taken=%b target=%h, want all 0",
                   cyc, bus.pred_valid, bus.pred_hit, bus.pred_taken, bus.pred_target);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_responses: got %0d outstanding, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
